// File: rtl/fetch_aligner_pkg.sv
// Shared types for the fetch aligner: fault codes, fetch package and aligned instruction records.
package fetch_aligner_pkg;

    localparam int FETCH_ID_W = 5;

    typedef logic [FETCH_ID_W-1:0] FetchID_t;

    typedef enum logic [1:0] {
        FAULT_NONE   = 2'd0,
        FAULT_ACCESS = 2'd1,
        FAULT_PAGE   = 2'd2,
        FAULT_TRUNC  = 2'd3
    } FetchFault_t;

    typedef struct packed {
        logic [127:0] instrs;
        logic [27:0]  pc;
        FetchID_t     fetch_id;
        logic [2:0]   first_valid;
        logic [2:0]   last_valid;
        logic         pred_taken;
        logic [2:0]   pred_pos;
        logic [30:0]  pred_target;
        FetchFault_t  fault;
    } FetchPkt_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        compr;
        FetchID_t    fetch_id;
        logic        pred_taken;
        logic [30:0] pred_target;
        FetchFault_t fault;
    } AlignedInstr;

    function automatic AlignedInstr make_instr(
        input logic [31:0] instr,
        input logic [31:0] pc,
        input logic        compr,
        input FetchID_t    fetch_id,
        input logic        pred_taken,
        input logic [30:0] pred_target,
        input FetchFault_t fault
    );
        AlignedInstr r;
        r.instr       = instr;
        r.pc          = pc;
        r.compr       = compr;
        r.fetch_id    = fetch_id;
        r.pred_taken  = pred_taken;
        r.pred_target = pred_target;
        r.fault       = fault;
        return r;
    endfunction

endpackage

// File: rtl/fetch_pkt_fifo.sv
// Small package FIFO; extra pointer MSB separates full from empty, occupancy kept in a register.
module fetch_pkt_fifo
    import fetch_aligner_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  FetchPkt_t push_data,
    input  logic      pop,
    output FetchPkt_t head,
    output logic      empty,
    output logic      almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - 1);

    FetchPkt_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push     = push && !full && !flush;
    assign do_pop      = pop && !empty && !flush;
    assign head        = mem[rd_ptr[AW-1:0]];
    assign almost_full = (count >= AF_LEVEL);

    // Package storage; contents are don't-care until written so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Pointer and occupancy update; flush empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_aligner.sv
// Splits buffered fetch packages into aligned RV32/RVC instructions, NUM_OUT per cycle.
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter int NUM_OUT  = 4,
    parameter int BUF_PKTS = 4,
    parameter int FID_W    = FETCH_ID_W
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          IN_flush,
    input  logic                          IN_valid,
    input  logic [127:0]                  IN_instrs,
    input  logic [27:0]                   IN_pc,
    input  logic [FID_W-1:0]              IN_fetchID,
    input  logic [2:0]                    IN_firstValid,
    input  logic [2:0]                    IN_lastValid,
    input  logic                          IN_predTaken,
    input  logic [2:0]                    IN_predPos,
    input  logic [30:0]                   IN_predTarget,
    input  logic [1:0]                    IN_fetchFault,
    output logic                          OUT_stall,
    input  logic                          IN_stall,
    output logic [NUM_OUT-1:0]            OUT_valid,
    output logic [NUM_OUT-1:0][31:0]      OUT_instr,
    output logic [NUM_OUT-1:0][31:0]      OUT_pc,
    output logic [NUM_OUT-1:0]            OUT_compr,
    output logic [NUM_OUT-1:0][FID_W-1:0] OUT_fetchID,
    output logic [NUM_OUT-1:0]            OUT_predTaken,
    output logic [NUM_OUT-1:0][30:0]      OUT_predTarget,
    output logic [NUM_OUT-1:0][1:0]       OUT_fault
);
    localparam int SW = $clog2(NUM_OUT);
    localparam logic [SW:0] SLOTS_FULL = (SW+1)'(NUM_OUT);

    FetchPkt_t    in_pkt;
    FetchPkt_t    head;
    logic         fifo_empty;
    logic         fifo_af;
    logic         push;
    logic         pop_req;

    logic [2:0]   cursor_q, cursor_d;
    logic         started_q, started_d;
    logic         pend_valid_q, pend_valid_d;
    logic [15:0]  pend_half_q, pend_half_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [27:0]  pend_pkt_pc_q, pend_pkt_pc_d;
    FetchID_t     pend_fid_q, pend_fid_d;

    AlignedInstr        out_q  [NUM_OUT];
    AlignedInstr        slot_d [NUM_OUT];
    logic [NUM_OUT-1:0] out_valid_q;
    logic [NUM_OUT-1:0] valid_d;

    logic [SW:0]  n;
    logic [3:0]   start;
    logic         stop;
    logic         skip;
    logic         scan;
    logic [15:0]  hw;
    logic [15:0]  hw_next;
    logic [143:0] ext;

    assign in_pkt.instrs      = IN_instrs;
    assign in_pkt.pc          = IN_pc;
    assign in_pkt.fetch_id    = IN_fetchID;
    assign in_pkt.first_valid = IN_firstValid;
    assign in_pkt.last_valid  = IN_lastValid;
    assign in_pkt.pred_taken  = IN_predTaken;
    assign in_pkt.pred_pos    = IN_predPos;
    assign in_pkt.pred_target = IN_predTarget;
    assign in_pkt.fault       = FetchFault_t'(IN_fetchFault);

    assign push      = IN_valid && !fifo_af && !IN_flush;
    assign OUT_stall = fifo_af;
    assign OUT_valid = out_valid_q;

    fetch_pkt_fifo #(.DEPTH(BUF_PKTS)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (IN_flush),
        .push        (push),
        .push_data   (in_pkt),
        .pop         (pop_req && !IN_stall),
        .head        (head),
        .empty       (fifo_empty),
        .almost_full (fifo_af)
    );

    // Extract the next group of instructions from the head package (and any pending low half).
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) slot_d[i] = '0;
        valid_d       = '0;
        pop_req       = 1'b0;
        cursor_d      = cursor_q;
        started_d     = started_q;
        pend_valid_d  = pend_valid_q;
        pend_half_d   = pend_half_q;
        pend_pc_d     = pend_pc_q;
        pend_pkt_pc_d = pend_pkt_pc_q;
        pend_fid_d    = pend_fid_q;
        n       = '0;
        start   = {1'b0, started_q ? cursor_q : head.first_valid};
        stop    = 1'b0;
        skip    = 1'b0;
        scan    = 1'b0;
        hw      = '0;
        hw_next = '0;
        ext     = {16'h0, head.instrs};

        if (!fifo_empty) begin
            if (pend_valid_q) begin
                pend_valid_d = 1'b0;
                if (head.fault == FAULT_NONE && head.first_valid == 3'd0 &&
                    head.pc == pend_pkt_pc_q + 28'd1 &&
                    head.fetch_id == FetchID_t'(pend_fid_q + 1'b1)) begin
                    slot_d[0] = make_instr({head.instrs[15:0], pend_half_q}, pend_pc_q, 1'b0,
                                           head.fetch_id, head.pred_taken && head.pred_pos == 3'd0,
                                           head.pred_target, FAULT_NONE);
                    valid_d[0] = 1'b1;
                    n     = (SW+1)'(1);
                    start = 4'd1;
                    scan  = 1'b1;
                end else begin
                    slot_d[0] = make_instr({16'h0, pend_half_q}, pend_pc_q, 1'b0, pend_fid_q,
                                           1'b0, '0, FAULT_TRUNC);
                    valid_d[0] = 1'b1;
                end
            end else if (head.fault != FAULT_NONE) begin
                slot_d[0] = make_instr(32'h0, {head.pc, head.first_valid, 1'b0}, 1'b0,
                                       head.fetch_id, 1'b0, '0, head.fault);
                valid_d[0] = 1'b1;
                pop_req    = 1'b1;
            end else begin
                scan = 1'b1;
            end

            if (scan) begin
                for (int h = 0; h < 8; h++) begin
                    hw      = ext[16*h +: 16];
                    hw_next = ext[16*(h+1) +: 16];
                    if (skip) begin
                        skip = 1'b0;
                    end else if (!stop && 4'(h) >= start && 3'(h) <= head.last_valid) begin
                        if (n == SLOTS_FULL) begin
                            stop     = 1'b1;
                            cursor_d = 3'(h);
                        end else if (hw[1:0] == 2'b11 && h == 7) begin
                            pend_valid_d  = 1'b1;
                            pend_half_d   = hw;
                            pend_pc_d     = {head.pc, 3'd7, 1'b0};
                            pend_pkt_pc_d = head.pc;
                            pend_fid_d    = head.fetch_id;
                        end else if (hw[1:0] == 2'b11 && 3'(h+1) > head.last_valid) begin
                            slot_d[n[SW-1:0]]  = make_instr({16'h0, hw}, {head.pc, 3'(h), 1'b0}, 1'b0,
                                                            head.fetch_id, 1'b0, '0, FAULT_TRUNC);
                            valid_d[n[SW-1:0]] = 1'b1;
                            n = n + 1'b1;
                        end else if (hw[1:0] == 2'b11) begin
                            slot_d[n[SW-1:0]]  = make_instr({hw_next, hw}, {head.pc, 3'(h), 1'b0}, 1'b0,
                                                            head.fetch_id,
                                                            head.pred_taken && head.pred_pos == 3'(h+1),
                                                            head.pred_target, FAULT_NONE);
                            valid_d[n[SW-1:0]] = 1'b1;
                            n    = n + 1'b1;
                            skip = 1'b1;
                        end else begin
                            slot_d[n[SW-1:0]]  = make_instr({16'h0, hw}, {head.pc, 3'(h), 1'b0}, 1'b1,
                                                            head.fetch_id,
                                                            head.pred_taken && head.pred_pos == 3'(h),
                                                            head.pred_target, FAULT_NONE);
                            valid_d[n[SW-1:0]] = 1'b1;
                            n = n + 1'b1;
                        end
                    end
                end
                if (stop) started_d = 1'b1;
                else      pop_req   = 1'b1;
            end

            if (pop_req) begin
                started_d = 1'b0;
                cursor_d  = 3'd0;
            end
        end
    end

    // Output and alignment state registers; flush clears, decode stall freezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q         <= '{default: '0};
            out_valid_q   <= '0;
            cursor_q      <= '0;
            started_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_half_q   <= '0;
            pend_pc_q     <= '0;
            pend_pkt_pc_q <= '0;
            pend_fid_q    <= '0;
        end else if (IN_flush) begin
            out_valid_q  <= '0;
            cursor_q     <= '0;
            started_q    <= 1'b0;
            pend_valid_q <= 1'b0;
        end else if (!IN_stall) begin
            out_q         <= slot_d;
            out_valid_q   <= valid_d;
            cursor_q      <= cursor_d;
            started_q     <= started_d;
            pend_valid_q  <= pend_valid_d;
            pend_half_q   <= pend_half_d;
            pend_pc_q     <= pend_pc_d;
            pend_pkt_pc_q <= pend_pkt_pc_d;
            pend_fid_q    <= pend_fid_d;
        end
    end

    // Unpack the registered slot records onto the flat output ports.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            OUT_instr[i]      = out_q[i].instr;
            OUT_pc[i]         = out_q[i].pc;
            OUT_compr[i]      = out_q[i].compr;
            OUT_fetchID[i]    = out_q[i].fetch_id;
            OUT_predTaken[i]  = out_q[i].pred_taken;
            OUT_predTarget[i] = out_q[i].pred_target;
            OUT_fault[i]      = out_q[i].fault;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: one task per scenario with hand-computed expectations.
module tb_fetch_aligner;
    localparam int NUM_OUT = 4;
    localparam int FID_W   = 5;

    logic clk = 1'b0;
    logic rst;
    logic in_flush, in_valid, in_stall;
    logic [127:0] in_instrs;
    logic [27:0] in_pc;
    logic [FID_W-1:0] in_fetch_id;
    logic [2:0] in_first, in_last, in_pred_pos;
    logic in_pred_taken;
    logic [30:0] in_pred_target;
    logic [1:0] in_fault;
    logic out_stall;
    logic [NUM_OUT-1:0] out_valid, out_compr, out_pred_taken;
    logic [NUM_OUT-1:0][31:0] out_instr, out_pc;
    logic [NUM_OUT-1:0][FID_W-1:0] out_fetch_id;
    logic [NUM_OUT-1:0][30:0] out_pred_target;
    logic [NUM_OUT-1:0][1:0] out_fault;

    int total = 0;
    int bad   = 0;

    fetch_aligner #(.NUM_OUT(NUM_OUT), .BUF_PKTS(4), .FID_W(FID_W)) dut (
        .clk(clk), .rst(rst), .IN_flush(in_flush), .IN_valid(in_valid),
        .IN_instrs(in_instrs), .IN_pc(in_pc), .IN_fetchID(in_fetch_id),
        .IN_firstValid(in_first), .IN_lastValid(in_last), .IN_predTaken(in_pred_taken),
        .IN_predPos(in_pred_pos), .IN_predTarget(in_pred_target), .IN_fetchFault(in_fault),
        .OUT_stall(out_stall), .IN_stall(in_stall), .OUT_valid(out_valid),
        .OUT_instr(out_instr), .OUT_pc(out_pc), .OUT_compr(out_compr),
        .OUT_fetchID(out_fetch_id), .OUT_predTaken(out_pred_taken),
        .OUT_predTarget(out_pred_target), .OUT_fault(out_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_instrs = '0; in_pc = '0; in_fetch_id = '0;
        in_first = '0; in_last = '0; in_pred_taken = 1'b0; in_pred_pos = 3'd7;
        in_pred_target = '0; in_fault = '0;
    endtask

    task automatic drive_pkt(input logic [27:0] pc, input logic [4:0] fid, input logic [2:0] first,
                             input logic [2:0] last, input logic [127:0] instrs, input logic [1:0] fault,
                             input logic pt, input logic [2:0] pp, input logic [30:0] tgt);
        in_valid = 1'b1; in_pc = pc; in_fetch_id = fid; in_first = first; in_last = last;
        in_instrs = instrs; in_fault = fault; in_pred_taken = pt; in_pred_pos = pp; in_pred_target = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_flush = 1'b0; in_stall = 1'b0;
        idle_inputs();
        step(); step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0000", out_valid); end
        total++; if (out_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b exp=0", out_stall); end
        rst = 1'b0;
        step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL post_reset_valid got=%b exp=0000", out_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        drive_pkt(28'h100, 5'd1, 3'd0, 3'd7, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        idle_inputs();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL seq_latency got=%b exp=0000", out_valid); end
        step();
        total++; if (out_valid !== 4'b1111) begin bad++; $display("[TB] FAIL seq_c1_valid got=%b exp=1111", out_valid); end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h1000 + 32'(2 * i);
            total++; if (out_pc[i] !== exp_pc) begin bad++; $display("[TB] FAIL seq_c1_pc%0d got=%h exp=%h", i, out_pc[i], exp_pc); end
        end
        total++; if (out_instr[0] !== 32'h1 || out_compr !== 4'b1111) begin bad++; $display("[TB] FAIL seq_c1_instr got=%h/%b exp=00000001/1111", out_instr[0], out_compr); end
        step();
        total++; if (out_valid !== 4'b1111) begin bad++; $display("[TB] FAIL seq_c2_valid got=%b exp=1111", out_valid); end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h1008 + 32'(2 * i);
            total++; if (out_pc[i] !== exp_pc) begin bad++; $display("[TB] FAIL seq_c2_pc%0d got=%h exp=%h", i, out_pc[i], exp_pc); end
        end
        step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL seq_pop_valid got=%b exp=0000", out_valid); end
    endtask

    task automatic test_straddle();
        logic [127:0] a;
        a = {8{16'h0001}};
        a[127:112] = 16'h0013;
        drive_pkt(28'h100, 5'd3, 3'd7, 3'd7, a, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        drive_pkt(28'h101, 5'd4, 3'd0, 3'd0, 128'h0, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        idle_inputs();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL strad_hold_valid got=%b exp=0000", out_valid); end
        step();
        total++; if (out_valid !== 4'b0001) begin bad++; $display("[TB] FAIL strad_valid got=%b exp=0001", out_valid); end
        total++; if (out_instr[0] !== 32'h00000013) begin bad++; $display("[TB] FAIL strad_instr got=%h exp=00000013", out_instr[0]); end
        total++; if (out_pc[0] !== 32'h100E) begin bad++; $display("[TB] FAIL strad_pc got=%h exp=0000100e", out_pc[0]); end
        total++; if (out_fetch_id[0] !== 5'd4) begin bad++; $display("[TB] FAIL strad_fid got=%0d exp=4", out_fetch_id[0]); end
        total++; if (out_compr[0] !== 1'b0 || out_fault[0] !== 2'd0) begin bad++; $display("[TB] FAIL strad_compr_fault got=%b/%0d exp=0/0", out_compr[0], out_fault[0]); end
        step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL strad_end_valid got=%b exp=0000", out_valid); end
    endtask

    task automatic test_straddle_break();
        logic [127:0] a;
        a = {8{16'h0001}};
        a[127:112] = 16'h0013;
        drive_pkt(28'h100, 5'd3, 3'd7, 3'd7, a, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        drive_pkt(28'h101, 5'd4, 3'd2, 3'd3, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        idle_inputs();
        step();
        total++; if (out_valid !== 4'b0001) begin bad++; $display("[TB] FAIL brk_trunc_valid got=%b exp=0001", out_valid); end
        total++; if (out_fault[0] !== 2'd3) begin bad++; $display("[TB] FAIL brk_trunc_fault got=%0d exp=3", out_fault[0]); end
        total++; if (out_pc[0] !== 32'h100E) begin bad++; $display("[TB] FAIL brk_trunc_pc got=%h exp=0000100e", out_pc[0]); end
        step();
        total++; if (out_valid !== 4'b0011) begin bad++; $display("[TB] FAIL brk_next_valid got=%b exp=0011", out_valid); end
        total++; if (out_pc[0] !== 32'h1014 || out_pc[1] !== 32'h1016) begin bad++; $display("[TB] FAIL brk_next_pc got=%h,%h exp=00001014,00001016", out_pc[0], out_pc[1]); end
        total++; if (out_fault[0] !== 2'd0) begin bad++; $display("[TB] FAIL brk_next_fault got=%0d exp=0", out_fault[0]); end
        step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL brk_end_valid got=%b exp=0000", out_valid); end
    endtask

    task automatic test_fault();
        drive_pkt(28'h080, 5'd1, 3'd4, 3'd7, {8{16'h0001}}, 2'd2, 1'b0, 3'd7, 31'h0);
        step();
        idle_inputs();
        step();
        total++; if (out_valid !== 4'b0001) begin bad++; $display("[TB] FAIL fault_valid got=%b exp=0001", out_valid); end
        total++; if (out_fault[0] !== 2'd2) begin bad++; $display("[TB] FAIL fault_code got=%0d exp=2", out_fault[0]); end
        total++; if (out_pc[0] !== 32'h808) begin bad++; $display("[TB] FAIL fault_pc got=%h exp=00000808", out_pc[0]); end
        total++; if (out_instr[0] !== 32'h0) begin bad++; $display("[TB] FAIL fault_instr got=%h exp=00000000", out_instr[0]); end
        step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL fault_pop_valid got=%b exp=0000", out_valid); end
    endtask

    task automatic test_pred();
        logic [127:0] p;
        p = '0;
        p[15:0] = 16'h0001; p[31:16] = 16'h0003; p[47:32] = 16'h0000; p[63:48] = 16'h0001;
        drive_pkt(28'h500, 5'd2, 3'd0, 3'd3, p, 2'd0, 1'b1, 3'd2, 31'h1234567);
        step();
        idle_inputs();
        step();
        total++; if (out_valid !== 4'b0111) begin bad++; $display("[TB] FAIL pred_valid got=%b exp=0111", out_valid); end
        total++; if (out_instr[1] !== 32'h00000003 || out_compr[1] !== 1'b0) begin bad++; $display("[TB] FAIL pred_rv32 got=%h/%b exp=00000003/0", out_instr[1], out_compr[1]); end
        total++; if (out_pc[1] !== 32'h5002 || out_pc[2] !== 32'h5006) begin bad++; $display("[TB] FAIL pred_pcs got=%h,%h exp=00005002,00005006", out_pc[1], out_pc[2]); end
        total++; if (out_pred_taken[2:0] !== 3'b010) begin bad++; $display("[TB] FAIL pred_taken got=%b exp=010", out_pred_taken[2:0]); end
        total++; if (out_pred_target[1] !== 31'h1234567) begin bad++; $display("[TB] FAIL pred_target got=%h exp=1234567", out_pred_target[1]); end
        step();
    endtask

    task automatic test_back_to_back();
        drive_pkt(28'h200, 5'd0, 3'd0, 3'd3, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        drive_pkt(28'h201, 5'd1, 3'd0, 3'd3, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        total++; if (out_pc[0] !== 32'h2000 || out_valid !== 4'b1111) begin bad++; $display("[TB] FAIL b2b_p0 got=%h/%b exp=00002000/1111", out_pc[0], out_valid); end
        in_stall = 1'b1;
        drive_pkt(28'h202, 5'd2, 3'd0, 3'd3, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        total++; if (out_stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_occ2_stall got=%b exp=0", out_stall); end
        drive_pkt(28'h203, 5'd3, 3'd0, 3'd3, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        total++; if (out_stall !== 1'b1) begin bad++; $display("[TB] FAIL b2b_occ3_stall got=%b exp=1", out_stall); end
        total++; if (out_pc[0] !== 32'h2000 || out_valid !== 4'b1111) begin bad++; $display("[TB] FAIL b2b_frozen got=%h/%b exp=00002000/1111", out_pc[0], out_valid); end
        drive_pkt(28'h204, 5'd4, 3'd0, 3'd3, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        total++; if (out_stall !== 1'b1 || out_pc[0] !== 32'h2000) begin bad++; $display("[TB] FAIL b2b_held got=%b/%h exp=1/00002000", out_stall, out_pc[0]); end
        in_stall = 1'b0;
        step();
        total++; if (out_pc[0] !== 32'h2010 || out_fetch_id[0] !== 5'd1) begin bad++; $display("[TB] FAIL b2b_p1 got=%h/%0d exp=00002010/1", out_pc[0], out_fetch_id[0]); end
        total++; if (out_stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_release_stall got=%b exp=0", out_stall); end
        step();
        idle_inputs();
        total++; if (out_pc[0] !== 32'h2020 || out_fetch_id[0] !== 5'd2) begin bad++; $display("[TB] FAIL b2b_p2 got=%h/%0d exp=00002020/2", out_pc[0], out_fetch_id[0]); end
        step();
        total++; if (out_pc[0] !== 32'h2030 || out_fetch_id[0] !== 5'd3) begin bad++; $display("[TB] FAIL b2b_p3 got=%h/%0d exp=00002030/3", out_pc[0], out_fetch_id[0]); end
        step();
        total++; if (out_pc[0] !== 32'h2040 || out_valid !== 4'b1111) begin bad++; $display("[TB] FAIL b2b_p4 got=%h/%b exp=00002040/1111", out_pc[0], out_valid); end
        step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL b2b_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_flush();
        logic [127:0] a;
        a = {8{16'h0001}};
        a[127:112] = 16'h0013;
        drive_pkt(28'h300, 5'd8, 3'd7, 3'd7, a, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        drive_pkt(28'h400, 5'd20, 3'd0, 3'd3, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        in_stall = 1'b1;
        drive_pkt(28'h500, 5'd21, 3'd0, 3'd3, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        drive_pkt(28'h600, 5'd22, 3'd0, 3'd3, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        in_stall = 1'b0;
        total++; if (out_valid !== 4'b0000 || out_stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_clear got=%b/%b exp=0000/0", out_valid, out_stall); end
        drive_pkt(28'h301, 5'd9, 3'd0, 3'd0, {8{16'h0001}}, 2'd0, 1'b0, 3'd7, 31'h0);
        step();
        idle_inputs();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL flush_empty got=%b exp=0000", out_valid); end
        step();
        total++; if (out_valid !== 4'b0001 || out_fault[0] !== 2'd0) begin bad++; $display("[TB] FAIL flush_post got=%b/%0d exp=0001/0", out_valid, out_fault[0]); end
        total++; if (out_pc[0] !== 32'h3010 || out_instr[0] !== 32'h1) begin bad++; $display("[TB] FAIL flush_post_pc got=%h/%h exp=00003010/00000001", out_pc[0], out_instr[0]); end
        step();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("[TB] FAIL flush_end got=%b exp=0000", out_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_straddle();
        test_straddle_break();
        test_fault();
        test_pred();
        test_back_to_back();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Sits directly downstream of the instruction fetch stage and upstream of decode.
- Consumes 8-halfword fetch packages and buffers them in a small package FIFO.
- Splits them into RV32/RVC instructions, including 32-bit instructions that straddle two packages.
- Emits up to NUM_OUT aligned instructions per cycle with per-instruction PC, fetch ID, prediction and fault info.

Parameters:
- NUM_OUT, 4, instruction slots emitted per cycle.
- BUF_PKTS, 4, package FIFO depth (power of two).
- FID_W, 5, fetch ID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- IN_flush  in  1  redirect (backend or decode branch taken); discard everything
- IN_valid  in  1  fetch package valid
- IN_instrs  in  128  halfword k at bits [16k+15:16k]
- IN_pc  in  28  package address (PC[31:4])
- IN_fetchID  in  FID_W  package fetch ID
- IN_firstValid  in  3  first valid halfword offset
- IN_lastValid  in  3  last valid halfword offset
- IN_predTaken  in  1  predicted-taken branch ends at IN_predPos
- IN_predPos  in  3  halfword offset of predicted branch's last halfword; 7 = none
- IN_predTarget  in  31  predicted target PC[31:1]
- IN_fetchFault  in  2  0 none, 1 access fault, 2 page fault
- OUT_stall  out  1  fetch must not present a new package
- IN_stall  in  1  decode cannot accept outputs
- OUT_valid  out  NUM_OUT  slot valid, program order from slot 0
- OUT_instr  out  NUM_OUT x 32  instruction bits; compressed = upper 16 bits zero
- OUT_pc  out  NUM_OUT x 32  PC of first halfword
- OUT_compr  out  NUM_OUT  16-bit instruction
- OUT_fetchID  out  NUM_OUT x FID_W  fetch ID of the package holding the last halfword
- OUT_predTaken  out  NUM_OUT  predicted taken
- OUT_predTarget  out  NUM_OUT x 31  valid when predTaken
- OUT_fault  out  NUM_OUT x 2  fault code; 3 = truncated instruction

Behaviour:
- Reset (async):
  - FIFO empty, cursor 0, pending-half invalid.
  - All OUT_valid 0, OUT_stall 0.
- Accept:
  - A package is written when IN_valid && !OUT_stall && !IN_flush.
  - OUT_stall = (occupancy >= BUF_PKTS-1). It is decoded from registered state only, which leaves one slack entry for an in-flight package.
- Extraction (combinational, head package only, starting at cursor; cursor loads firstValid on a new head):
  - Halfword h with bits[1:0]==2'b11 starts a 32-bit instruction; otherwise it is compressed.
  - Scan stops after NUM_OUT instructions or past lastValid.
  - predTaken is set on the instruction whose last halfword offset == IN_predPos and IN_predTaken == 1.
- Straddle: a 32-bit instruction starting at offset 7 with lastValid == 7:
  - Its low half is saved in the pending register with its PC, and the head pops.
  - The next package completes it in slot 0 with halfword 0 when all of: firstValid == 0, pc == saved pc+1, fetchID == saved+1 (mod 2^FID_W).
  - Otherwise the pending instruction is emitted alone with fault 3 and the new package is processed the following cycle.
- Fault package (IN_fetchFault != 0):
  - Emits one slot with fault code, pc = {pc, firstValid, 1'b0}, instr 0, then pops.
  - A pending half is first emitted with fault 3.
- Pop/advance:
  - Only when !IN_stall.
  - Cursor advances past consumed halfwords; the head pops when the cursor passes lastValid.
- Outputs:
  - Registered.
  - Hold all values while IN_stall.
  - Unused slots have valid 0.
- Latency: package accepted at edge E appears on outputs after edge E+1 if the FIFO was empty and IN_stall is low.
- Flush:
  - Next edge empties the FIFO, clears pending and cursor, zeroes OUT_valid.
  - Flush overrides a same-cycle accept and IN_stall.
- Wrap-around:
  - FIFO pointers are log2(BUF_PKTS)+1 bits.
  - full/empty are determined by the MSB compare.

Decomposition:
- Shared package: fetch fault enum (adds FAULT_TRUNC=3), FetchID_t width, and an AlignedInstr struct (instr, pc, compr, fetchID, predTaken, predTarget, fault) used on the output bus.
- Natural sub-module: fetch_pkt_fifo (BUF_PKTS x package, registered occupancy, full-minus-one flag).

Test Plan:
- Eight compressed halfwords (0x0001) at pc 0x100, first 0, last 7 -> cycle 1: 4 slots with pc 0x1000/2/4/6; cycle 2: 0x1008..0x100E; head pops.
- Package A (pc 0x100, fid 3) with halfword 7 = 0x0013, package B (pc 0x101, fid 4) halfword 0 = 0x0000 -> slot 0 instr 0x00000013, pc 0x100E, fetchID 4, compr 0.
- Same as the previous scenario but B has firstValid 2 (or pc 0x200) -> pending emitted alone, fault 3, pc 0x100E; B processed next cycle from offset 2.
- Package with fetchFault 2, firstValid 4, pc 0x80 -> single slot, fault 2, pc 0x808; no other slots valid.
- Hold IN_stall while presenting 4 packages -> OUT_stall rises after occupancy 3; outputs frozen; no package lost or duplicated after release.
- IN_flush together with IN_valid while FIFO holds 2 packages and a pending half -> next cycle all OUT_valid 0, OUT_stall 0; a post-flush package emits with no fault 3.
